// File: rtl/mul_seq.sv
// mul_seq -- multi-cycle 8x8 unsigned shift-and-add multiplier controller.
//
// The block borrows the shared ALU for one ADD per multiplier bit. It uses a
// request/grant handshake for this. The right shifts happen in local
// registers. The product is available on ProductHi/ProductLo when Done pulses.
// The product stays there until the next accepted Start.
//
// Ports:
//   CLK, Reset_n         clock (rising edge), async active-low reset
//   Start                multiply request, sampled only in IDLE
//   OperandA / OperandB  multiplicand / multiplier, captured on accepted Start
//   Busy, Done           status (Busy in ADD/SHR, Done one-cycle pulse)
//   ProductHi/Lo         16-bit product (hi/lo registers)
//   AluReq/AluGnt        shared ALU request / grant
//   AluOp/AluA/AluB      ALU command and operands (operands are 0 outside ADD)
//   AluOut/AluOver       ALU sum and carry out
//
// Build option: MUL_SEQ_SKIP_ZERO_EN. When this is defined, an iteration whose
// multiplier bit is 0 skips the ADD state. The block then goes straight to
// SHR, and the latency becomes 9 + popcount(OperandB) cycles.
//
// state | meaning
// IDLE  | waiting for Start
// ADD   | requesting the ALU; {carry,hi} <= sum on grant
// SHR   | 17-bit right shift of {carry,hi,lo}, advance bit count
// DONE  | one-cycle Done pulse
module mul_seq (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [7:0] OperandA,
  input  logic [7:0] OperandB,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] ProductHi,
  output logic [7:0] ProductLo,
  output logic       AluReq,
  input  logic       AluGnt,
  output logic [3:0] AluOp,
  output logic [7:0] AluA,
  output logic [7:0] AluB,
  input  logic [7:0] AluOut,
  input  logic       AluOver
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SHR  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     w_first_iter;
  state_t     w_next_iter;
  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic [7:0] r_mcand;
  logic       r_carry;
  logic [2:0] r_cnt;

  // Choose the state that starts an iteration. With skip-zero enabled, a zero
  // multiplier bit needs no add, so that iteration goes straight to SHR. At
  // that point, lo[1] is the bit that the coming shift moves into lo[0].
`ifdef MUL_SEQ_SKIP_ZERO_EN
  assign w_first_iter = OperandB[0] ? S_ADD : S_SHR;
  assign w_next_iter  = r_lo[1]     ? S_ADD : S_SHR;
`else
  assign w_first_iter = S_ADD;
  assign w_next_iter  = S_ADD;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = w_first_iter;
      S_ADD:   if (AluGnt) w_state_nxt = S_SHR;
      S_SHR:   w_state_nxt = (r_cnt == 3'd7) ? S_DONE : w_next_iter;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hi    <= 8'h00;
      r_lo    <= 8'h00;
      r_mcand <= 8'h00;
      r_carry <= 1'b0;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_hi    <= 8'h00;
            r_lo    <= OperandB;
            r_mcand <= OperandA;
            r_carry <= 1'b0;
            r_cnt   <= 3'd0;
          end
        end
        S_ADD: begin
          if (AluGnt) begin
            {r_carry, r_hi} <= {AluOver, AluOut};
          end
        end
        S_SHR: begin
          // The carry of the last add moves into hi[7], so no product bit is lost.
          {r_carry, r_hi, r_lo} <= {1'b0, r_carry, r_hi, r_lo[7:1]};
          r_cnt <= r_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (r_state == S_ADD) || (r_state == S_SHR);
  assign Done      = (r_state == S_DONE);
  assign AluReq    = (r_state == S_ADD);
  assign AluOp     = 4'b0000;
  assign AluA      = (r_state == S_ADD) ? r_hi : 8'h00;
  assign AluB      = ((r_state == S_ADD) && r_lo[0]) ? r_mcand : 8'h00;
  assign ProductHi = r_hi;
  assign ProductLo = r_lo;

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle 8x8 unsigned shift-and-add multiplier controller for the 8-bit datapath. It computes a 16-bit product by issuing one ADD per multiplier bit to the shared ALU through a request/grant port, and performs the shifts in its own registers. It sits beside the ALU in the core and is selected by the decoder for the multiply instruction. An external arbiter shares the ALU between this block and the normal instruction path.

## Interface
Parameters: none.

Ports:
- CLK  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  request a multiply; sampled only in IDLE
- OperandA  in  8  multiplicand; captured on accepted Start
- OperandB  in  8  multiplier; captured on accepted Start
- Busy  out  1  high in ADD and SHR states
- Done  out  1  one-cycle pulse in DONE state
- ProductHi  out  8  upper product byte
- ProductLo  out  8  lower product byte
- AluReq  out  1  high in ADD state: requests the shared ALU
- AluGnt  in  1  ALU granted this cycle
- AluOp  out  4  constant 4'b0000 (ADD)
- AluA  out  8  hi register in ADD, else 0
- AluB  out  8  in ADD: mcand if lo[0]=1, otherwise 0; 0 outside ADD
- AluOut  in  8  ALU sum
- AluOver  in  1  ALU carry out

## Operation
- Internal registers:
  - hi[7:0], lo[7:0] (ProductHi/ProductLo are hi/lo directly)
  - mcand[7:0]
  - carry (1 bit)
  - cnt[2:0]
  - state
- States: IDLE, ADD, SHR, DONE.
- IDLE:
  - Start=1 loads hi=0, lo=OperandB, mcand=OperandA, carry=0, cnt=0.
  - Next state is ADD.
- ADD:
  - AluReq=1.
  - If AluGnt=1: {carry,hi} <= {AluOver,AluOut}, then go to SHR.
  - If AluGnt=0: hold every register and stay in ADD.
- SHR:
  - {carry,hi,lo} <= {1'b0,carry,hi,lo[7:1]}, i.e. a 17-bit right shift.
  - cnt <= cnt+1.
  - If cnt==7, go to DONE; otherwise go to ADD.
- DONE:
  - Done=1 for one cycle, then go to IDLE.
  - Start is ignored in this cycle.
- Start is ignored while Busy=1. OperandA and OperandB are don't-care after the accepting edge.
- ProductHi/ProductLo hold their last value after DONE until the next accepted Start. They are not valid while Busy=1.
- Arithmetic rule: the result equals OperandA*OperandB mod 2^16, which is exact. carry is never lost because it is shifted into hi[7].
- Reset, asynchronous at any time including mid-operation:
  - state=IDLE.
  - hi, lo, mcand, carry and cnt are all 0.
  - The in-flight multiply is abandoned.
  - Busy=0, Done=0, AluReq=0, AluA=0, AluB=0, AluOp=4'b0000.

## Timing
- Start is accepted at edge E0.
- With AluGnt held at 1, operation is fixed-latency:
  - Iteration i (i=0..7) spends cycle 2i+1 in ADD and cycle 2i+2 in SHR.
  - Done is high during cycle 17 after E0.
  - A new Start is accepted at the edge that ends the DONE cycle +1, i.e. in IDLE at earliest cycle 18.
- Each cycle with AluGnt=0 in ADD adds exactly one cycle of latency.
- The ALU is combinational. AluOut/AluOver are sampled at the same edge that ends the granted ADD cycle.
- All outputs are registered-state decodes. There is no combinational path from inputs to outputs except AluGnt, which has no effect on outputs.

## Configuration
- MUL_SEQ_SKIP_ZERO_EN
- Defined:
  - On entry to an iteration, if lo[0]=0 the ADD state is bypassed and the block goes straight to SHR. No AluReq is raised for that bit.
  - Latency is 9 + popcount(OperandB) cycles to Done, assuming no stalls.
- Undefined:
  - Every iteration passes through ADD, with AluB=0 when lo[0]=0.
  - Fixed 17-cycle latency.
- Result values are identical in both builds.

## Test plan
- Reset, then Start with A=13, B=11 (gnt=1):
  - Done pulse in cycle 17 with ProductHi=0x00, ProductLo=0x8F.
  - Busy high in cycles 1-16.
- A=0xFF, B=0xFF:
  - Product 0xFE01.
  - Checks the carry path through AluOver on every ADD.
- A=0x5A, B=0x00:
  - Product 0x0000.
  - Done in cycle 17 without the macro, cycle 9 with MUL_SEQ_SKIP_ZERO_EN.
- A=0x80, B=0x01, AluGnt held low for 3 cycles during the first ADD:
  - Product 0x0080.
  - Done in cycle 20 without the macro.
  - Registers unchanged during the stall.
- Second Start pulsed in cycles 5 and 17 of a running multiply:
  - Both are ignored; the first result is correct.
  - A Start in cycle 18 is accepted.
- Reset_n low in cycle 9 of a multiply:
  - All outputs are 0 immediately and state is IDLE.
  - The next multiply, A=3, B=7, yields 0x0015.
